// File: rtl/mfp_ahb_gpio_irq.sv
// AHB-Lite GPIO slave: atomic set/clear outputs, synchronised inputs, edge IRQs (W1C).
// Define MFP_GPIO_DEBOUNCE_EN to insert the prescaled two-sample debounce stage.
module mfp_ahb_gpio_irq #(
    parameter int N_IN      = 16,
    parameter int N_OUT     = 16,
    parameter int DB_CYCLES = 50000
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [3:0]       HADDR,
    input  logic [1:0]       HTRANS,
    input  logic [31:0]      HWDATA,
    input  logic             HWRITE,
    input  logic             HSEL,
    output logic [31:0]      HRDATA,
    input  logic [N_IN-1:0]  IO_IN,
    output logic [N_OUT-1:0] IO_OUT,
    output logic             IO_IRQ
);

    localparam logic [3:0] A_IN     = 4'd0;
    localparam logic [3:0] A_OUT    = 4'd1;
    localparam logic [3:0] A_SET    = 4'd2;
    localparam logic [3:0] A_CLR    = 4'd3;
    localparam logic [3:0] A_IRQ_EN = 4'd4;
    localparam logic [3:0] A_EDGE   = 4'd5;
    localparam logic [3:0] A_STATUS = 4'd6;
    localparam logic [3:0] A_RAW    = 4'd7;

    logic             r_wr_en;
    logic [3:0]       r_wr_addr;
    logic [N_IN-1:0]  r_sync1;
    logic [N_IN-1:0]  r_sync2;
    logic [N_IN-1:0]  w_db;
    logic [N_IN-1:0]  r_db_prev;
    logic [N_IN-1:0]  w_rise;
    logic [N_IN-1:0]  w_fall;
    logic [N_IN-1:0]  w_ev;
    logic [N_IN-1:0]  w_clr;
    logic [N_IN-1:0]  r_irq_en;
    logic [N_IN-1:0]  r_edge_sel;
    logic [N_IN-1:0]  r_status;
    logic [N_OUT-1:0] r_out;
    logic             r_irq;
    logic [31:0]      r_rdata;
    logic [31:0]      w_rdata;
    logic             w_unused_hwdata;

    assign w_unused_hwdata = ^HWDATA;

    // Address phase qualified into a single write-pending flag.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= 4'd0;
        end else begin
            r_wr_en   <= HSEL & HWRITE & (HTRANS != 2'b00);
            r_wr_addr <= HADDR;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= IO_IN;
            r_sync2 <= r_sync1;
        end
    end

`ifdef MFP_GPIO_DEBOUNCE_EN
    localparam int            PW   = $clog2(DB_CYCLES);
    localparam logic [PW-1:0] PMAX = PW'(DB_CYCLES - 1);

    logic [PW-1:0]   r_presc;
    logic            w_tick;
    logic [N_IN-1:0] r_samp;
    logic [N_IN-1:0] r_db;
    logic [N_IN-1:0] w_same;

    assign w_tick = (r_presc == PMAX);
    assign w_same = ~(r_sync2 ^ r_samp);

    // A new level is accepted only when two consecutive ticks agree.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_presc <= '0;
            r_samp  <= '0;
            r_db    <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_samp <= r_sync2;
                r_db   <= (w_same & r_sync2) | (~w_same & r_db);
            end
        end
    end

    assign w_db = r_db;
`else
    logic w_unused_db;

    assign w_unused_db = (DB_CYCLES > 1);
    assign w_db        = r_sync2;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_db_prev <= '0;
        end else begin
            r_db_prev <= w_db;
        end
    end

    assign w_rise = w_db & ~r_db_prev;
    assign w_fall = ~w_db & r_db_prev;
    assign w_ev   = r_irq_en & ((r_edge_sel & w_fall) | (~r_edge_sel & w_rise));
    assign w_clr  = (r_wr_en && r_wr_addr == A_STATUS) ? HWDATA[N_IN-1:0] : '0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_out      <= '0;
            r_irq_en   <= '0;
            r_edge_sel <= '0;
        end else if (r_wr_en) begin
            case (r_wr_addr)
                A_OUT:    r_out      <= HWDATA[N_OUT-1:0];
                A_SET:    r_out      <= r_out | HWDATA[N_OUT-1:0];
                A_CLR:    r_out      <= r_out & ~HWDATA[N_OUT-1:0];
                A_IRQ_EN: r_irq_en   <= HWDATA[N_IN-1:0];
                A_EDGE:   r_edge_sel <= HWDATA[N_IN-1:0];
                default:  ;
            endcase
        end
    end

    // New events are OR-ed in after the clear, so a simultaneous set wins.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_status <= (r_status & ~w_clr) | w_ev;
            r_irq    <= |r_status;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (HADDR)
            A_IN:     w_rdata[N_IN-1:0]  = w_db;
            A_OUT:    w_rdata[N_OUT-1:0] = r_out;
            A_IRQ_EN: w_rdata[N_IN-1:0]  = r_irq_en;
            A_EDGE:   w_rdata[N_IN-1:0]  = r_edge_sel;
            A_STATUS: w_rdata[N_IN-1:0]  = r_status;
            A_RAW:    w_rdata[N_IN-1:0]  = r_sync2;
            default:  ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rdata;
        end
    end

    assign HRDATA = r_rdata;
    assign IO_OUT = r_out;
    assign IO_IRQ = r_irq;

endmodule

// File: tb/tb_mfp_ahb_gpio_irq.sv
// Directed, table-driven bench for mfp_ahb_gpio_irq (works with or without
// MFP_GPIO_DEBOUNCE_EN; debounce period fixed at 4 cycles).
`timescale 1ns/1ps
module tb_mfp_ahb_gpio_irq;

    localparam int NI = 16;
    localparam int NO = 16;
    localparam int DB = 4;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [3:0]    HADDR;
    logic [1:0]    HTRANS;
    logic [31:0]   HWDATA;
    logic          HWRITE;
    logic          HSEL;
    logic [31:0]   HRDATA;
    logic [NI-1:0] IO_IN;
    logic [NO-1:0] IO_OUT;
    logic          IO_IRQ;

    mfp_ahb_gpio_irq #(
        .N_IN(NI),
        .N_OUT(NO),
        .DB_CYCLES(DB)
    ) dut (
        .HCLK(HCLK),
        .HRESET(HRESET),
        .HADDR(HADDR),
        .HTRANS(HTRANS),
        .HWDATA(HWDATA),
        .HWRITE(HWRITE),
        .HSEL(HSEL),
        .HRDATA(HRDATA),
        .IO_IN(IO_IN),
        .IO_OUT(IO_OUT),
        .IO_IRQ(IO_IRQ)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t        vt[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] d;
    logic        saw_in1;
    logic        saw_raw1;
    logic        got;
    int          lat;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic idle_bus();
        HSEL   = 1'b0;
        HWRITE = 1'b0;
        HTRANS = 2'b00;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] v);
        HADDR  = a;
        HSEL   = 1'b1;
        HWRITE = 1'b1;
        HTRANS = 2'b10;
        tick(1);
        HWDATA = v;
        idle_bus();
        tick(1);
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] v);
        HADDR  = a;
        HSEL   = 1'b1;
        HWRITE = 1'b0;
        HTRANS = 2'b10;
        tick(1);
        v = HRDATA;
        idle_bus();
    endtask

    task automatic add(input logic wr, input logic [3:0] a,
                       input logic [31:0] v, input logic [31:0] e,
                       input string nm);
        vec_t t;
        t.wr = wr; t.addr = a; t.data = v; t.exp = e; t.nm = nm;
        vt.push_back(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Write rows compare IO_OUT after commit; read rows compare read data.
        add(0, 4'd4, 0, 32'h0, "rst_irq_en");
        add(0, 4'd5, 0, 32'h0, "rst_edge_sel");
        add(0, 4'd6, 0, 32'h0, "rst_status");
        add(0, 4'd0, 0, 32'h0, "in_idle");
        add(0, 4'd7, 0, 32'h0, "raw_idle");
        add(1, 4'd1, 32'h0000_00F0, 32'hF0, "out_wr");
        add(1, 4'd2, 32'h0000_000F, 32'hFF, "out_set");
        add(1, 4'd3, 32'h0000_0030, 32'hCF, "out_clr");
        add(0, 4'd1, 0, 32'h0000_00CF, "out_rd");
        add(0, 4'd2, 0, 32'h0, "set_rd");
        add(0, 4'd3, 0, 32'h0, "clr_rd");
        add(1, 4'd4, 32'hFFFF_FFFF, 32'hCF, "irq_en_wr");
        add(0, 4'd4, 0, 32'h0000_FFFF, "irq_en_rd");
        add(1, 4'd4, 32'h0, 32'hCF, "irq_en_wr0");
        add(0, 4'd4, 0, 32'h0, "irq_en_rd0");
        add(1, 4'd5, 32'h1234_5678, 32'hCF, "edge_wr");
        add(0, 4'd5, 0, 32'h0000_5678, "edge_rd");
        add(1, 4'd5, 32'h0, 32'hCF, "edge_wr0");
        add(1, 4'd9, 32'hFFFF_FFFF, 32'hCF, "hole_wr");
        add(0, 4'd9, 0, 32'h0, "hole9_rd");
        add(0, 4'd15, 0, 32'h0, "hole15_rd");
        add(1, 4'd1, 32'h1234_5678, 32'h5678, "out_wide");
        add(1, 4'd3, 32'hFFFF_FFFF, 32'h0, "out_clr_all");

        HRESET = 1'b1;
        HADDR  = 4'd0;
        HWDATA = 32'h0;
        IO_IN  = '1;
        idle_bus();
        tick(3);
        chk("rst_io_out", 32'(IO_OUT), 32'h0);
        chk("rst_io_irq", 32'(IO_IRQ), 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        IO_IN  = '0;
        HRESET = 1'b0;
        tick(30);

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].wr) begin
                bus_wr(vt[i].addr, vt[i].data);
                chk(vt[i].nm, 32'(IO_OUT), vt[i].exp);
            end else begin
                bus_rd(vt[i].addr, d);
                chk(vt[i].nm, d, vt[i].exp);
            end
        end

`ifdef MFP_GPIO_DEBOUNCE_EN
        // Bounce period equals the tick period, so consecutive ticks always disagree.
        saw_in1  = 1'b0;
        saw_raw1 = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    IO_IN[0] = (k % 2 == 0);
                    repeat (DB) @(posedge HCLK);
                    #1;
                end
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    bus_rd(4'd0, d);
                    if (d[0]) saw_in1 = 1'b1;
                    bus_rd(4'd7, d);
                    if (d[0]) saw_raw1 = 1'b1;
                end
            end
        join
        chk("db_bounce_in", 32'(saw_in1), 32'h0);
        chk("db_bounce_raw", 32'(saw_raw1), 32'h1);
        IO_IN[0] = 1'b1;
        bus_rd(4'd0, d);
        chk("db_not_instant", d, 32'h0);
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            bus_rd(4'd0, d);
            if (d[0]) got = 1'b1;
        end
        chk("db_accept", 32'(got), 32'h1);
        IO_IN[0] = 1'b0;
        tick(20);
`else
        IO_IN = 16'hA5C3;
        tick(3);
        bus_rd(4'd0, d);
        chk("in_direct", d, 32'h0000_A5C3);
        bus_rd(4'd7, d);
        chk("raw_direct", d, 32'h0000_A5C3);
        IO_IN = '0;
        tick(4);
`endif

        bus_wr(4'd5, 32'h0);
        bus_wr(4'd4, 32'h1);
        IO_IN[0] = 1'b1;
        d = 32'h0;
        for (int k = 0; k < 40 && d == 0; k++) bus_rd(4'd6, d);
        chk("rise_status", d, 32'h1);
        chk("rise_irq", 32'(IO_IRQ), 32'h1);
        bus_wr(4'd6, 32'h1);
        chk("w1c_irq_lag", 32'(IO_IRQ), 32'h1);
        tick(1);
        chk("w1c_irq", 32'(IO_IRQ), 32'h0);
        bus_rd(4'd6, d);
        chk("w1c_status", d, 32'h0);
        IO_IN[0] = 1'b0;
        tick(20);
        bus_rd(4'd6, d);
        chk("fall_ignored", d, 32'h0);

        bus_wr(4'd5, 32'h8);
        bus_wr(4'd4, 32'h8);
        IO_IN[3] = 1'b1;
        tick(20);
        bus_rd(4'd6, d);
        chk("rise3_ignored", d, 32'h0);
        IO_IN[3] = 1'b0;
        d = 32'h0;
        for (int k = 0; k < 40 && d == 0; k++) bus_rd(4'd6, d);
        chk("fall3_status", d, 32'h8);
        IO_IN[2] = 1'b1;
        tick(20);
        IO_IN[2] = 1'b0;
        tick(20);
        bus_rd(4'd6, d);
        chk("dis2_status", d, 32'h8);
        bus_wr(4'd6, 32'h8);
        bus_rd(4'd6, d);
        chk("w1c3_status", d, 32'h0);

        // Measure event latency at a fixed prescaler phase, then replay it.
        bus_wr(4'd5, 32'h0);
        bus_wr(4'd4, 32'h1);
        while (cyc % DB != 0) tick(1);
        IO_IN[0] = 1'b1;
        lat = 0;
        while (!IO_IRQ && lat < 40) begin
            tick(1);
            lat++;
        end
        chk("sw_measure", 32'(IO_IRQ), 32'h1);
        if (lat < 3) lat = 3;
        bus_wr(4'd6, 32'h1);
        IO_IN[0] = 1'b0;
        tick(20);
        bus_rd(4'd6, d);
        chk("sw_pre", d, 32'h0);
        while (cyc % DB != 0) tick(1);
        IO_IN[0] = 1'b1;
        repeat (lat - 3) tick(1);
        bus_wr(4'd6, 32'h1);
        tick(2);
        bus_rd(4'd6, d);
        chk("set_wins", d, 32'h1);
        chk("set_wins_irq", 32'(IO_IRQ), 32'h1);

        HADDR  = 4'd4;
        HSEL   = 1'b1;
        HWRITE = 1'b1;
        HTRANS = 2'b10;
        tick(1);
        HWDATA = 32'hFFFF;
        idle_bus();
        HRESET = 1'b1;
        tick(1);
        HRESET = 1'b0;
        tick(1);
        bus_rd(4'd4, d);
        chk("rst_data_phase", d, 32'h0);

        HRESET = 1'b1;
        HADDR  = 4'd1;
        HSEL   = 1'b1;
        HWRITE = 1'b1;
        HTRANS = 2'b10;
        tick(1);
        HRESET = 1'b0;
        HWDATA = 32'hFF;
        idle_bus();
        tick(2);
        chk("rst_addr_phase", 32'(IO_OUT), 32'h0);
        bus_rd(4'd1, d);
        chk("rst_addr_out_rd", d, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
